// File: rtl/iroh_pkg.sv
// -----------------------------------------------------------------------------
// iroh_pkg
// Shared constants and types for the CPU's on-chip memory.
//   MEM_ADDR_WIDTH : word address width (8 bits -> 256 words)
//   WORD_WIDTH     : memory word width (16 bits)
//   MEM_DEPTH      : number of words held by internal_mem
//   word_t         : one memory word
//   mem_addr_t     : one word address
// -----------------------------------------------------------------------------
package iroh_pkg;

   localparam int MEM_ADDR_WIDTH = 8;
   localparam int WORD_WIDTH     = 16;
   localparam int MEM_DEPTH      = 2 ** MEM_ADDR_WIDTH;

   typedef logic [WORD_WIDTH-1:0]     word_t;
   typedef logic [MEM_ADDR_WIDTH-1:0] mem_addr_t;

endpackage : iroh_pkg

// File: rtl/internal_mem.sv
// -----------------------------------------------------------------------------
// internal_mem
// Single-port synchronous RAM, 256 x 16, used as program/data memory.
// Reads have one cycle of latency; writes are write-through, so the written
// word also appears on wordOut after the write edge.
//
// Ports:
//   clk      : system clock, rising-edge active
//   rst_n    : asynchronous active-low reset; clears wordOut and every word
//   addr     : word address, every value is a valid location
//   enable   : access strobe; nothing happens while low
//   wEnable  : write select, only meaningful when enable is high
//   newWord  : write data
//   wordOut  : registered read data; holds its value on idle cycles
// -----------------------------------------------------------------------------
module internal_mem
   import iroh_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  enable,
   input  logic                  wEnable,
   input  logic [DATA_WIDTH-1:0] newWord,
   output logic [DATA_WIDTH-1:0] wordOut
);

   word_t mem_q [MEM_DEPTH];
   word_t word_out_q;
   word_t word_out_d;
   logic  wr_en;

   // Next-state decode for the read register and the write strobe.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      wr_en      = 1'b0;
      word_out_d = word_out_q;
      if (enable) begin
         if (wEnable) begin
            wr_en      = 1'b1;
            word_out_d = newWord;   // write-through: new data is visible at once
         end else begin
            word_out_d = mem_q[addr];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset as well because software relies on the
         // memory reading back zero after reset; this rules out block-RAM
         // inference and builds the array from flops.
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         word_out_q <= '0;
      end else begin
         word_out_q <= word_out_d;
         if (wr_en) begin
            mem_q[addr] <= newWord;
         end
      end
   end

   assign wordOut = word_out_q;

endmodule : internal_mem

// File: tb/tb_internal_mem.sv
// -----------------------------------------------------------------------------
// tb_internal_mem
// Self-checking bench for internal_mem. A plain array plus an "expected output"
// variable model the memory; each access updates the model and compares
// wordOut one step after the sampling edge.
// -----------------------------------------------------------------------------
module tb_internal_mem;

   logic        clk;
   logic        rst_n;
   logic [7:0]  addr;
   logic        enable;
   logic        wEnable;
   logic [15:0] newWord;
   logic [15:0] wordOut;

   int errors = 0;
   int checks = 0;

   // Reference model
   logic [15:0] ref_mem [256];
   logic [15:0] exp_out;

   internal_mem dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (addr),
      .enable  (enable),
      .wEnable (wEnable),
      .newWord (newWord),
      .wordOut (wordOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      exp_out = 16'h0000;
   endtask

   // One clock of stimulus: drive on the falling edge, sample 1 time unit
   // after the rising edge, then compare against the model.
   task automatic access(input logic en, input logic we, input logic [7:0] a,
                         input logic [15:0] d, input string tag);
      @(negedge clk);
      enable  = en;
      wEnable = we;
      addr    = a;
      newWord = d;
      @(posedge clk);
      #1;
      if (en) begin
         if (we) begin
            ref_mem[a] = d;
            exp_out    = d;
         end else begin
            exp_out = ref_mem[a];
         end
      end
      check(tag, wordOut, exp_out);
   endtask

   task automatic rd(input logic [7:0] a, input string tag);
      access(1'b1, 1'b0, a, 16'($urandom), tag);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d, input string tag);
      access(1'b1, 1'b1, a, d, tag);
   endtask

   initial begin
      logic [7:0]  ra;
      logic [15:0] rdat;
      logic        ren, rwe;

      rst_n   = 1'b1;
      enable  = 1'b0;
      wEnable = 1'b0;
      addr    = 8'h00;
      newWord = 16'h0000;
      model_reset();

      // Asynchronous reset assertion, held across two clock edges.
      #2 rst_n = 1'b0;
      #1 check("reset_async", wordOut, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      #1 check("reset_held", wordOut, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Reads of a freshly reset memory.
      rd(8'd0,   "rd0_after_reset");
      rd(8'd1,   "rd1_after_reset");
      rd(8'd255, "rd255_after_reset");

      // Write-through and read-back.
      wr(8'd1, 16'hC350, "wr1_through");
      rd(8'd1, "rd1_c350");
      rd(8'd0, "rd0_zero");

      // Disabled write must not touch storage or output.
      access(1'b0, 1'b1, 8'd2, 16'h1234, "disabled_write_hold");
      rd(8'd2, "rd2_untouched");

      // Boundary addresses back-to-back, no aliasing.
      wr(8'd255, 16'hFFFF, "wr255");
      wr(8'd0,   16'h0001, "wr0");
      rd(8'd255, "rd255_ffff");
      rd(8'd0,   "rd0_0001");

      // Idle hold after reading 0xC350.
      rd(8'd1, "rd1_before_idle");
      for (int i = 0; i < 5; i++) begin
         access(1'b0, 1'($urandom), 8'($urandom), 16'($urandom), "idle_hold");
      end

      // Consecutive writes to one address: last write wins.
      wr(8'd7, 16'hAAAA, "wr7_a");
      wr(8'd7, 16'h5555, "wr7_b");
      rd(8'd7, "rd7_last_wins");

      // Randomized traffic; half the cycles use a small address pool so
      // reads frequently hit previously written words.
      for (int i = 0; i < 400; i++) begin
         ren  = ($urandom_range(0, 3) != 0);
         rwe  = 1'($urandom);
         rdat = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 3))
               0: ra = 8'd0;
               1: ra = 8'd255;
               2: ra = 8'd1;
               default: ra = 8'($urandom_range(2, 5));
            endcase
         end else begin
            ra = 8'($urandom);
         end
         access(ren, rwe, ra, rdat, "random");
      end

      // Mid-operation reset pulse between edges, with a write pending
      // across an edge during reset.
      wr(8'd1, 16'hBEEF, "wr1_before_reset");
      @(negedge clk);
      enable  = 1'b1;
      wEnable = 1'b1;
      addr    = 8'd9;
      newWord = 16'h9999;
      #1 rst_n = 1'b0;
      #1 check("reset_mid_async", wordOut, 16'h0000);
      @(posedge clk);
      #1 check("reset_mid_edge_ignored", wordOut, 16'h0000);
      @(negedge clk);
      enable  = 1'b0;
      wEnable = 1'b0;
      rst_n   = 1'b1;
      model_reset();

      rd(8'd1,   "rd1_after_mid_reset");
      rd(8'd9,   "rd9_write_lost");
      rd(8'd255, "rd255_after_mid_reset");
      rd(8'd0,   "rd0_after_mid_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_internal_mem
